// File: rtl/zube_regbank.sv
// Bank of NUM_REGS 8-bit registers on an asynchronous 8-bit CPU bus.
// Strobes, address and data are synchronised; each strobe assertion yields one access.
module zube_regbank #(
   parameter logic [15:0] BASE_ADDRESS  = 16'hA000,
   parameter int unsigned NUM_REGS      = 4,
   parameter logic [15:0] READONLY_MASK = 16'h0000,
   parameter logic [7:0]  RESET_VALUE   = 8'h00,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  write_strobe_b,
   input  logic                  read_strobe_b,
   input  logic [15:0]           address_bus,
   inout  wire  [7:0]            data_bus,
   output logic                  bus_dir,
   output logic [8*NUM_REGS-1:0] reg_out,
   input  logic [8*NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0]   reg_written
);

   typedef enum logic [1:0] {IDLE, READ, WAIT_HIGH} state_t;

   localparam logic [16:0] NUM_REGS_W = 17'(NUM_REGS);

   state_t state, state_nxt;

   logic [1:0]             rst_sync;
   logic                   rst_int_b;
   logic [SYNC_STAGES-1:0] wr_sync;
   logic [SYNC_STAGES-1:0] rd_sync;
   logic [15:0]            addr_sync [SYNC_STAGES];
   logic [7:0]             data_sync [SYNC_STAGES];

   logic        s_wr_b;
   logic        s_rd_b;
   logic [15:0] s_addr;
   logic [7:0]  s_data;
   logic [16:0] offset;
   logic [3:0]  idx;
   logic        hit;
   logic        wr_en;
   logic        rd_load;
   logic [7:0]  rd_val;
   logic [7:0]  rdbuf;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int_b = rst_sync[1];

   always_ff @(posedge clk or negedge rst_int_b) begin
      if (!rst_int_b) begin
         wr_sync <= '1;
         rd_sync <= '1;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= '0;
            data_sync[i] <= '0;
         end
      end else begin
         wr_sync      <= {wr_sync[SYNC_STAGES-2:0], write_strobe_b};
         rd_sync      <= {rd_sync[SYNC_STAGES-2:0], read_strobe_b};
         addr_sync[0] <= address_bus;
         data_sync[0] <= data_bus;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= addr_sync[i-1];
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   assign s_wr_b = wr_sync[SYNC_STAGES-1];
   assign s_rd_b = rd_sync[SYNC_STAGES-1];
   assign s_addr = addr_sync[SYNC_STAGES-1];
   assign s_data = data_sync[SYNC_STAGES-1];

   // 17-bit offset so addresses below the base wrap high and never alias a hit.
   assign offset = {1'b0, s_addr} - {1'b0, BASE_ADDRESS};
   assign hit    = (s_addr >= BASE_ADDRESS) && (offset < NUM_REGS_W);
   assign idx    = offset[3:0];

   always_comb begin
      rd_val = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (idx == 4'(i)) begin
            rd_val = READONLY_MASK[i] ? reg_in[8*i +: 8] : reg_out[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int_b) begin
      if (!rst_int_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!s_wr_b) begin
               state_nxt = WAIT_HIGH;
            end else if (!s_rd_b) begin
               state_nxt = hit ? READ : WAIT_HIGH;
            end
         end
         READ: begin
            if (s_rd_b) begin
               state_nxt = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (s_wr_b && s_rd_b) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_en   = 1'b0;
      rd_load = 1'b0;
      if (state == IDLE) begin
         wr_en   = !s_wr_b && hit && !READONLY_MASK[idx];
         rd_load = s_wr_b && !s_rd_b && hit;
      end
   end

   always_ff @(posedge clk or negedge rst_int_b) begin
      if (!rst_int_b) begin
         reg_out     <= {NUM_REGS{RESET_VALUE}};
         reg_written <= '0;
         rdbuf       <= '0;
      end else begin
         reg_written <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (idx == 4'(i))) begin
               reg_out[8*i +: 8] <= s_data;
               reg_written[i]    <= 1'b1;
            end
         end
         if (rd_load) begin
            rdbuf <= rd_val;
         end
      end
   end

   // Raw pins gate the driver so the bus is released without synchroniser delay.
   assign bus_dir  = reset_b && (state == READ) && !read_strobe_b;
   assign data_bus = bus_dir ? rdbuf : 8'hzz;

endmodule

// File: tb/tb_zube_regbank.sv
// Randomised bench for zube_regbank against an array-based register model.
// Directed cases cover reset, latency, long strobes, read-only/miss, dual strobes, mid-read reset.
module tb_zube_regbank;

   localparam logic [15:0] BASE = 16'hA000;
   localparam int          NR   = 4;
   localparam logic [15:0] ROM  = 16'h0002;
   localparam logic [7:0]  RV   = 8'h5A;
   localparam int          SS   = 2;

   logic        clk     = 1'b0;
   logic        reset_b = 1'b0;
   logic        wr_b    = 1'b1;
   logic        rd_b    = 1'b1;
   logic [15:0] addr    = '0;
   logic        tb_oe   = 1'b0;
   logic [7:0]  tb_dat  = '0;
   logic [31:0] reg_in  = 32'h0000_C300;
   wire  [7:0]  data_bus;
   logic        bus_dir;
   logic [31:0] reg_out;
   logic [3:0]  reg_written;

   int         n_chk   = 0;
   int         n_bad   = 0;
   int         pulses  = 0;
   logic [3:0] last_pw = '0;
   logic [7:0] mdl [NR];

   assign data_bus = tb_oe ? tb_dat : 8'hzz;

   zube_regbank #(
      .BASE_ADDRESS (BASE),
      .NUM_REGS     (NR),
      .READONLY_MASK(ROM),
      .RESET_VALUE  (RV),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk           (clk),
      .reset_b       (reset_b),
      .write_strobe_b(wr_b),
      .read_strobe_b (rd_b),
      .address_bus   (addr),
      .data_bus      (data_bus),
      .bus_dir       (bus_dir),
      .reg_out       (reg_out),
      .reg_in        (reg_in),
      .reg_written   (reg_written)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (|reg_written) begin
         pulses  = pulses + $countones(reg_written);
         last_pw = reg_written;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_hit(input logic [15:0] a);
      return (a >= BASE) && (int'(a) - int'(BASE) < NR);
   endfunction

   function automatic logic [7:0] exp_read(input int i);
      return ROM[i] ? reg_in[8*i +: 8] : mdl[i];
   endfunction

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++) check(tag, {24'd0, reg_out[8*i +: 8]}, {24'd0, mdl[i]});
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int len);
      int p0;
      int i;
      bit wr_ok;
      @(negedge clk);
      addr = a; tb_dat = d; tb_oe = 1'b1; p0 = pulses;
      @(negedge clk);
      wr_b = 1'b0;
      repeat (len) @(negedge clk);
      wr_b = 1'b1;
      repeat (SS + 4) @(negedge clk);
      tb_oe = 1'b0;
      i = int'(a) - int'(BASE);
      wr_ok = is_hit(a) && !ROM[i[3:0]];
      if (wr_ok) mdl[i] = d;
      check("wr_pulses", pulses - p0, wr_ok ? 1 : 0);
      if (wr_ok) check("wr_bit", {28'd0, last_pw}, 32'd1 << i);
      check_regs("wr_regs");
   endtask

   task automatic do_read(input logic [15:0] a, input int len);
      bit         seen;
      bit         hit;
      logic [7:0] got;
      int         i;
      seen = 1'b0; got = '0;
      hit = is_hit(a);
      i = int'(a) - int'(BASE);
      @(negedge clk);
      addr = a; tb_oe = 1'b0;
      @(negedge clk);
      rd_b = 1'b0;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         if (bus_dir && !seen) begin
            seen = 1'b1;
            got  = data_bus;
            if (hit) check("rd_data", {24'd0, got}, {24'd0, exp_read(i)});
            reg_in = ~reg_in;
         end
      end
      check("rd_dir", {31'd0, seen}, {31'd0, hit});
      if (seen) check("rd_frozen", {24'd0, data_bus}, {24'd0, got});
      rd_b = 1'b1;
      #1;
      check("rd_release", {31'd0, bus_dir}, 32'd0);
      repeat (SS + 4) @(negedge clk);
   endtask

   initial begin
      bit dir_seen;
      int p0;

      for (int i = 0; i < NR; i++) mdl[i] = RV;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      repeat (4) @(negedge clk);
      check_regs("reset_regs");
      check("reset_dir", {31'd0, bus_dir}, 32'd0);
      check("reset_pulse", {28'd0, reg_written}, 32'd0);

      // Write latency: pin strobe falls at a negedge, data appears after the third rising edge.
      @(negedge clk);
      addr = 16'hA002; tb_dat = 8'h3C; tb_oe = 1'b1; p0 = pulses;
      @(negedge clk);
      wr_b = 1'b0;
      repeat (2) @(negedge clk);
      check("wr_lat_early", {24'd0, reg_out[23:16]}, {24'd0, mdl[2]});
      @(negedge clk);
      check("wr_lat", {24'd0, reg_out[23:16]}, 32'h3C);
      repeat (3) @(negedge clk);
      wr_b = 1'b1;
      repeat (SS + 4) @(negedge clk);
      tb_oe = 1'b0;
      mdl[2] = 8'h3C;
      check("wr2_pulses", pulses - p0, 1);
      check("wr2_bit", {28'd0, last_pw}, 32'h4);
      do_read(16'hA002, 8);

      do_write(16'hA003, 8'h77, 50);

      reg_in = 32'h0000_C300;
      do_write(16'hA001, 8'hFF, 6);
      reg_in = 32'h0000_C300;
      do_read(16'hA001, 8);
      do_read(16'hA004, 8);

      // Both strobes low together: write wins and the bus is never driven.
      @(negedge clk);
      addr = 16'hA000; tb_dat = 8'h11; tb_oe = 1'b1; dir_seen = 1'b0;
      @(negedge clk);
      wr_b = 1'b0; rd_b = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus_dir) dir_seen = 1'b1;
      end
      wr_b = 1'b1; rd_b = 1'b1;
      repeat (SS + 4) @(negedge clk);
      tb_oe = 1'b0;
      mdl[0] = 8'h11;
      check("dual_dir", {31'd0, dir_seen}, 32'd0);
      check_regs("dual_regs");

      for (int n = 0; n < 40; n++) begin
         logic [15:0] a;
         a = BASE + 16'($urandom_range(0, 5));
         reg_in = $urandom;
         if ($urandom_range(0, 1) == 0) do_write(a, 8'($urandom), $urandom_range(6, 12));
         else                           do_read(a, $urandom_range(6, 12));
      end

      // Reset while the block is driving the bus.
      @(negedge clk);
      addr = 16'hA002; tb_oe = 1'b0; dir_seen = 1'b0;
      @(negedge clk);
      rd_b = 1'b0;
      for (int c = 0; c < 10 && !dir_seen; c++) begin
         @(negedge clk);
         if (bus_dir) dir_seen = 1'b1;
      end
      check("rst_rd_dir", {31'd0, dir_seen}, 32'd1);
      reset_b = 1'b0;
      #1;
      check("rst_release", {31'd0, bus_dir}, 32'd0);
      @(negedge clk);
      rd_b = 1'b1;
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < NR; i++) mdl[i] = RV;
      check_regs("rst_regs");
      check("rst_dir_after", {31'd0, bus_dir}, 32'd0);
      do_write(16'hA000, 8'hA5, 6);
      do_read(16'hA000, 8);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
